// File: rtl/pointwise_psum_collector.sv
// Accumulates pointwise partial sums across input-channel groups, then ReLU/saturates
// finished pixels into a show-ahead output FIFO.
module pointwise_psum_collector #(
    parameter int DATA_WIDTH             = 16,
    parameter int INCHANNEL_PARALLELISM  = 8,
    parameter int OUTCHANNEL_PARALLELISM = 8,
    parameter int MAX_OUT_CHANNEL        = 128,
    parameter int ACC_WIDTH              = 20,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [7:0]                                   input_channel,
    input  logic [7:0]                                   output_channel,
    input  logic [7:0]                                   output_size,
    input  logic                                         relu_en,
    input  logic                                         in_valid,
    input  logic [DATA_WIDTH*OUTCHANNEL_PARALLELISM-1:0] in_feature,
    input  logic [7:0]                                   in_ic_sel,
    input  logic [7:0]                                   in_oc_sel,
    input  logic [7:0]                                   in_h,
    input  logic [7:0]                                   in_w,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DATA_WIDTH*OUTCHANNEL_PARALLELISM-1:0] out_feature,
    output logic [7:0]                                   out_oc_sel,
    output logic [7:0]                                   out_h,
    output logic [7:0]                                   out_w,
    output logic                                         frame_done,
    output logic                                         overflow_err,
    output logic                                         proto_err
);
    localparam int DW     = DATA_WIDTH;
    localparam int ICP    = INCHANNEL_PARALLELISM;
    localparam int OCP    = OUTCHANNEL_PARALLELISM;
    localparam int FW     = DW * OCP;
    localparam int GROUPS = MAX_OUT_CHANNEL / OCP;
    localparam int GW     = $clog2(GROUPS);
    localparam int OW     = $clog2(OCP);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    localparam logic signed [ACC_WIDTH:0] ACC_HI = (ACC_WIDTH+1)'((1 << (ACC_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] ACC_LO = ~ACC_HI;
    localparam logic signed [ACC_WIDTH:0] DW_HI  = (ACC_WIDTH+1)'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] DW_LO  = ~DW_HI;

    typedef struct packed {
        logic [FW-1:0] feature;
        logic [7:0]    oc_sel;
        logic [7:0]    h;
        logic [7:0]    w;
    } entry_t;

    logic signed [ACC_WIDTH-1:0] acc [GROUPS][OCP];
    logic [GROUPS-1:0]           open_q;
    logic [GW-1:0]               g;
    logic                        beat_ok;
    logic                        last_ic;
    logic signed [ACC_WIDTH:0]   wide [OCP];
    logic signed [ACC_WIDTH:0]   fin [OCP];
    logic signed [ACC_WIDTH-1:0] acc_next [OCP];
    logic [FW-1:0]               final_data;

    logic                        stage_valid;
    entry_t                      stage_entry;
    entry_t                      mem [FIFO_DEPTH];
    entry_t                      head;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        push_ok;
    logic                        head_last;

    // wide[] is exact (one guard bit), so the ACC and DW clamps see the true sum.
    always_comb begin
        g          = in_oc_sel[OW +: GW];
        beat_ok    = in_valid && ({1'b0, in_oc_sel} < 9'(MAX_OUT_CHANNEL));
        last_ic    = ({1'b0, input_channel} <= 9'(ICP)) ||
                     ({1'b0, in_ic_sel} >= ({1'b0, input_channel} - 9'(ICP)));
        final_data = '0;
        for (int i = 0; i < OCP; i++) begin
            wide[i] = (ACC_WIDTH+1)'($signed(in_feature[DW*i +: DW]));
            if (in_ic_sel != 8'd0)
                wide[i] = wide[i] + (ACC_WIDTH+1)'(acc[g][i]);
            if (wide[i] > ACC_HI)
                acc_next[i] = ACC_HI[ACC_WIDTH-1:0];
            else if (wide[i] < ACC_LO)
                acc_next[i] = ACC_LO[ACC_WIDTH-1:0];
            else
                acc_next[i] = wide[i][ACC_WIDTH-1:0];
            fin[i] = (relu_en && wide[i][ACC_WIDTH]) ? '0 : wide[i];
            if (fin[i] > DW_HI)
                fin[i] = DW_HI;
            else if (fin[i] < DW_LO)
                fin[i] = DW_LO;
            final_data[DW*i +: DW] = fin[i][DW-1:0];
        end
    end

    // Accumulator contents are don't-care until a group is opened by an ic_sel==0 beat.
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            for (int i = 0; i < OCP; i++)
                acc[g][i] <= acc_next[i];
        end
    end

    // Output handshake: the head entry is offered while out_valid is high and is held
    // unchanged until the cycle where out_valid && out_ready, which consumes it.
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_feature = head.feature;
    assign out_oc_sel  = head.oc_sel;
    assign out_h       = head.h;
    assign out_w       = head.w;

    assign push      = stage_valid;
    assign pop       = out_valid && out_ready;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push_ok   = push && (!full || pop);
    assign head_last = (head.h == output_size - 8'd1) && (head.w == output_size - 8'd1) &&
                       ((output_channel <= 8'(OCP)) ||
                        ({1'b0, head.oc_sel} >= ({1'b0, output_channel} - 9'(OCP))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q       <= '0;
            proto_err    <= 1'b0;
            overflow_err <= 1'b0;
            frame_done   <= 1'b0;
            stage_valid  <= 1'b0;
            stage_entry  <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (in_valid && !beat_ok)
                proto_err <= 1'b1;
            if (beat_ok) begin
                if (in_ic_sel != 8'd0 && !open_q[g])
                    proto_err <= 1'b1;
                if (last_ic)
                    open_q[g] <= 1'b0;
                else if (in_ic_sel == 8'd0)
                    open_q[g] <= 1'b1;
            end
            stage_valid <= beat_ok && last_ic;
            stage_entry <= '{feature: final_data, oc_sel: in_oc_sel, h: in_h, w: in_w};

            if (push_ok) begin
                mem[wr_ptr] <= stage_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (push && full && !pop)
                overflow_err <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count      <= count + CW'(push_ok) - CW'(pop);
            frame_done <= pop && head_last;
        end
    end
endmodule

// File: tb/tb_pointwise_psum_collector.sv
// Directed bench for pointwise_psum_collector: vector table for single pixels plus
// hand-written FIFO, frame and error sequences.
module tb_pointwise_psum_collector;
    localparam int FW = 128;

    logic           clk;
    logic           rst_n;
    logic [7:0]     input_channel;
    logic [7:0]     output_channel;
    logic [7:0]     output_size;
    logic           relu_en;
    logic           in_valid;
    logic [FW-1:0]  in_feature;
    logic [7:0]     in_ic_sel;
    logic [7:0]     in_oc_sel;
    logic [7:0]     in_h;
    logic [7:0]     in_w;
    logic           out_valid;
    logic           out_ready;
    logic [FW-1:0]  out_feature;
    logic [7:0]     out_oc_sel;
    logic [7:0]     out_h;
    logic [7:0]     out_w;
    logic           frame_done;
    logic           overflow_err;
    logic           proto_err;

    int checks   = 0;
    int failures = 0;

    pointwise_psum_collector dut (
        .clk(clk), .rst_n(rst_n),
        .input_channel(input_channel), .output_channel(output_channel),
        .output_size(output_size), .relu_en(relu_en),
        .in_valid(in_valid), .in_feature(in_feature),
        .in_ic_sel(in_ic_sel), .in_oc_sel(in_oc_sel), .in_h(in_h), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_feature(out_feature),
        .out_oc_sel(out_oc_sel), .out_h(out_h), .out_w(out_w),
        .frame_done(frame_done), .overflow_err(overflow_err), .proto_err(proto_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    // driver tasks
    function automatic logic [FW-1:0] mk(input int v0, v1, v2, v3, v4, v5, v6, v7);
        logic [FW-1:0] r;
        r = {16'(v7), 16'(v6), 16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
        return r;
    endfunction

    function automatic logic [FW-1:0] all8(input int v);
        return mk(v, v, v, v, v, v, v, v);
    endfunction

    task automatic beat(input logic [7:0] ic, input logic [7:0] oc, input logic [7:0] h,
                        input logic [7:0] w, input logic [FW-1:0] f);
        @(negedge clk);
        in_valid   = 1'b1;
        in_ic_sel  = ic;
        in_oc_sel  = oc;
        in_h       = h;
        in_w       = w;
        in_feature = f;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            nb;
        logic          relu;
        logic [7:0]    oc;
        logic [FW-1:0] f [4];
        logic [FW-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    // scoreboard
    logic [23:0] exp_q [$];
    logic [23:0] e;
    logic        prev_last;
    int          fd_count;
    int          fd_bad;

    initial begin
        vecs[0] = '{nb: 1, relu: 1'b0, oc: 8'd0,
                    f: '{all8(100), '0, '0, '0}, exp: all8(100)};
        vecs[1] = '{nb: 4, relu: 1'b0, oc: 8'd8,
                    f: '{mk(1000,0,0,0,0,0,0,0), mk(-200,0,0,0,0,0,0,0),
                         mk(300,0,0,0,0,0,0,0), mk(-100,0,0,0,0,0,0,0)},
                    exp: mk(1000,0,0,0,0,0,0,0)};
        vecs[2] = '{nb: 4, relu: 1'b1, oc: 8'd16,
                    f: '{mk(0,30000,-10,-30000,0,0,0,0), mk(0,30000,5,-30000,0,0,0,0),
                         mk(0,30000,0,-30000,0,0,0,0), mk(0,30000,0,-30000,0,0,0,0)},
                    exp: mk(0,32767,0,0,0,0,0,0)};
        vecs[3] = '{nb: 4, relu: 1'b0, oc: 8'd16,
                    f: '{mk(0,30000,-10,-30000,0,0,0,0), mk(0,30000,5,-30000,0,0,0,0),
                         mk(0,30000,0,-30000,0,0,0,0), mk(0,30000,0,-30000,0,0,0,0)},
                    exp: mk(0,32767,-5,-32768,0,0,0,0)};
        vecs[4] = '{nb: 2, relu: 1'b0, oc: 8'd120,
                    f: '{mk(5,0,0,0,0,-3,0,32767), mk(7,0,0,0,0,-4,0,1), '0, '0},
                    exp: mk(12,0,0,0,0,-7,0,32767)};
        vecs[5] = '{nb: 3, relu: 1'b1, oc: 8'd64,
                    f: '{mk(-50,0,0,0,10,0,-32768,0), mk(20,0,0,0,-30,0,-32768,0),
                         mk(40,0,0,0,5,0,-32768,0), '0},
                    exp: mk(10,0,0,0,0,0,0,0)};

        rst_n = 1'b0; in_valid = 1'b0; in_feature = '0; in_ic_sel = '0; in_oc_sel = '0;
        in_h = '0; in_w = '0; out_ready = 1'b0; relu_en = 1'b0;
        input_channel = 8'd8; output_channel = 8'd128; output_size = 8'd8;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_overflow_err", overflow_err, 0);
        check("reset_proto_err", proto_err, 0);
        check("reset_out_feature", out_feature, 0);
        rst_n = 1'b1;

        // single-pixel vectors
        for (int n = 0; n < 6; n++) begin
            input_channel = 8'(vecs[n].nb * 8);
            relu_en       = vecs[n].relu;
            for (int b = 0; b < vecs[n].nb; b++)
                beat(8'(b * 8), vecs[n].oc, 8'(n), 8'd2, vecs[n].f[b]);
            idle();
            check($sformatf("vec%0d_valid_early", n), out_valid, 0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", n), out_valid, 1);
            check($sformatf("vec%0d_feature", n), out_feature, vecs[n].exp);
            check($sformatf("vec%0d_oc_sel", n), out_oc_sel, vecs[n].oc);
            check($sformatf("vec%0d_h", n), out_h, 8'(n));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("vec_proto_err", proto_err, 0);

        // FIFO full: five finals with no ready, fifth dropped
        input_channel = 8'd8; output_channel = 8'd8; relu_en = 1'b0;
        for (int k = 0; k < 5; k++)
            beat(8'd0, 8'd0, 8'(k), 8'd0, all8(k * 10 + 1));
        idle();
        @(negedge clk);
        check("full_overflow_err", overflow_err, 1);
        check("full_head_h", out_h, 0);
        beat(8'd0, 8'd0, 8'd9, 8'd0, all8(91));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd9};
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            check($sformatf("drain%0d_valid", k), out_valid, 1);
            check($sformatf("drain%0d_h", k), out_h, e[7:0]);
            if (k == 4)
                check("drain_push_on_pop_feature", out_feature, all8(91));
            else
                check($sformatf("drain%0d_feature", k), out_feature, all8(k * 10 + 1));
            @(negedge clk);
        end
        check("drain_empty", out_valid, 0);
        out_ready = 1'b0;

        // full frame: output_size=2, output_channel=16
        do_reset();
        input_channel = 8'd8; output_channel = 8'd16; output_size = 8'd2;
        out_ready = 1'b1; prev_last = 1'b0; fd_count = 0; fd_bad = 0;
        for (int h = 0; h < 2; h++)
            for (int w = 0; w < 2; w++)
                for (int oc = 0; oc < 16; oc += 8)
                    exp_q.push_back({8'(oc), 8'(h), 8'(w)});
        fork
            begin
                for (int h = 0; h < 2; h++)
                    for (int w = 0; w < 2; w++)
                        for (int oc = 0; oc < 16; oc += 8)
                            beat(8'd0, 8'(oc), 8'(h), 8'(w), all8(h * 100 + w * 10 + oc));
                idle();
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (frame_done) begin
                        fd_count++;
                        if (!prev_last) fd_bad++;
                    end
                    prev_last = 1'b0;
                    if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            check("frame_extra_output", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_pos", {out_oc_sel, out_h, out_w}, e);
                            check("frame_data", out_feature[15:0],
                                  16'(e[15:8] * 100 + e[7:0] * 10 + e[23:16]));
                            prev_last = (e == {8'd8, 8'd1, 8'd1});
                        end
                    end
                end
            end
        join
        check("frame_done_count", fd_count, 1);
        check("frame_done_timing", fd_bad, 0);
        check("frame_all_popped", exp_q.size(), 0);
        check("frame_overflow_err", overflow_err, 0);
        check("frame_proto_err", proto_err, 0);
        out_ready = 1'b0;

        // protocol errors and mid-stream reset
        do_reset();
        input_channel = 8'd32; output_channel = 8'd8; output_size = 8'd8;
        beat(8'd8, 8'd0, 8'd0, 8'd0, all8(1));
        idle();
        check("unopened_group_proto_err", proto_err, 1);
        do_reset();
        input_channel = 8'd8;
        beat(8'd0, 8'd128, 8'd0, 8'd0, all8(1));
        idle();
        check("oc_range_proto_err", proto_err, 1);
        @(negedge clk);
        check("oc_range_ignored", out_valid, 0);
        do_reset();
        beat(8'd0, 8'd0, 8'd1, 8'd0, all8(5));
        beat(8'd0, 8'd0, 8'd2, 8'd0, all8(6));
        beat(8'd0, 8'd200, 8'd3, 8'd0, all8(7));
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_proto_err", proto_err, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_proto_err", proto_err, 0);
        check("async_reset_overflow_err", overflow_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("stage_dropped_on_reset", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
